// File: rtl/spi_master.sv
// spi_master: single-slave SPI master, one DATA_WIDTH-bit frame per start.
// SCLK idles low, CS active low, MOSI launched on SCLK rise, MISO sampled on
// SCLK fall. Default bit order is LSB first.
// Build option: define SPI_MASTER_MSB_FIRST_EN to send and receive MSB first;
// frame timing is identical in both orders.
//
// state | meaning
// IDLE  | CS high, waiting for start
// SETUP | CS low, one SCLK half-period before the first edge
// XFER  | SCLK toggling, 2*DATA_WIDTH half-periods
// HOLD  | CS still low, SCLK low, one half-period after the last edge
// GAP   | CS high for one half-period of minimum deselect time
module spi_master #(
  parameter int unsigned CLK_DIV    = 3,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  busy,
  output logic                  done,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned DIV_W = 8;

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                state_q;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      div_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_sh_q;
  logic [DATA_WIDTH-1:0] rx_sh_q;
  logic [DATA_WIDTH-1:0] rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  sclk_q;
  logic                  cs_q;
  logic                  mosi_q;
  logic                  tick;
  logic                  tx_bit;
  logic [IDX_W-1:0]      bit_idx;

  // Half-period divider wrap, bit-order dependent tx bit select and rx shift.
  always_comb begin
    tick    = (div_q == DIV_W'(CLK_DIV - 1));
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    bit_idx = bit_cnt_q[IDX_W-1:0];
`ifdef SPI_MASTER_MSB_FIRST_EN
    tx_bit  = tx_sh_q[IDX_W'(DATA_WIDTH - 1) - bit_idx];
    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], MISO};
`else
    tx_bit  = tx_sh_q[bit_idx];
    rx_sh_d = {MISO, rx_sh_q[DATA_WIDTH-1:1]};
`endif
  end

  // Frame sequencer; every output is a register written here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_out_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          div_q  <= '0;
          sclk_q <= 1'b0;
          cs_q   <= 1'b1;
          if (start) begin
            tx_sh_q <= masterDataToSend;
            busy_q  <= 1'b1;
            cs_q    <= 1'b0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          div_q <= div_d;
          if (tick) begin
            bit_cnt_q <= '0;
            state_q   <= XFER;
          end
        end
        XFER: begin
          div_q <= div_d;
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              mosi_q <= tx_bit;
            end else begin
              sclk_q    <= 1'b0;
              rx_sh_q   <= rx_sh_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          div_q <= div_d;
          if (tick) begin
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            rx_out_q <= rx_sh_q;
            done_q   <= 1'b1;
            state_q  <= GAP;
          end
        end
        GAP: begin
          done_q <= 1'b0;
          div_q  <= div_d;
          if (tick) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign masterDataReceived = rx_out_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign SCLK               = sclk_q;
  assign CS                 = cs_q;
  assign MOSI               = mosi_q;

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-slave SPI master that drives the existing SPI slave over SCLK/CS/MOSI/MISO. It is the upstream stage feeding that slave.
- Accepts one parallel byte per transfer through a start/busy/done handshake, serialises it on MOSI and deserialises MISO into a parallel byte.
- Bus mode is fixed to match the slave: SCLK idles low, CS is active low, LSB first, MOSI launched on SCLK rising edge, MISO sampled on SCLK falling edge.

Parameters:
- CLK_DIV, 3: clk cycles per SCLK half-period; legal range 1..255.
- DATA_WIDTH, 8: bits per transfer.

Ports:
- clk  in  1  system clock; all logic on posedge clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  transfer request; sampled only in IDLE.
- masterDataToSend  in  DATA_WIDTH  byte to transmit; latched when start is accepted.
- masterDataReceived  out  DATA_WIDTH  last byte received; updated only at transfer end.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when masterDataReceived is valid.
- SCLK  out  1  serial clock, registered.
- CS  out  1  chip select, active low, registered.
- MOSI  out  1  serial data to the slave, registered.
- MISO  in  1  serial data from the slave.

Behaviour:
- Reset values: CS=1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=0, state=IDLE, counters=0.
- Reset mid-transfer aborts on that edge with the same values. The partial rx byte is discarded.
- All outputs are registered.
- A divider counter counts 0..CLK_DIV-1. A "tick" is the cycle where it wraps. The divider is cleared on every state entry.
- FSM states:
  - IDLE: CS=1, SCLK=0. If start=1: latch masterDataToSend into tx_sh, set busy=1, CS=0 on that edge, go to SETUP.
  - SETUP: hold for one half-period (CLK_DIV cycles), SCLK low. On tick, go to XFER with bit_cnt=0.
  - XFER: SCLK toggles on each tick, giving 2*DATA_WIDTH toggles.
    - Rising toggle: MOSI <= tx_sh[bit_cnt] on the same edge (LSB first).
    - Falling toggle: rx_sh <= {MISO, rx_sh[DATA_WIDTH-1:1]}, bit_cnt++. MISO is sampled in the cycle the falling toggle is registered.
    - After the DATA_WIDTH-th falling toggle, go to HOLD.
  - HOLD: CS stays low and SCLK low for CLK_DIV cycles. On tick: CS=1, MOSI=0, masterDataReceived <= rx_sh, done=1, go to GAP.
  - GAP: CS high for CLK_DIV cycles (minimum deselect time). done=0 after its one cycle. On tick: busy=0, go to IDLE.
- Latency: start sampled at edge k; CS falls at edge k; done is high in the cycle after edge k+(2+2*DATA_WIDTH)*CLK_DIV. busy clears CLK_DIV cycles later.
- start while busy=1 is ignored and not queued.
- A start held high across GAP is accepted on the first IDLE cycle, giving back-to-back transfers.
- masterDataToSend changes after acceptance have no effect on the current transfer.
- bit_cnt width is clog2(DATA_WIDTH)+1. It never wraps within a transfer.
- MISO is not synchronised here; CLK_DIV>=2 gives at least a full clk cycle of MISO settle time before sampling.

Optional Feature:
- Macro: SPI_MASTER_MSB_FIRST_EN.
- Defined: MOSI sends tx_sh[DATA_WIDTH-1-bit_cnt], and rx shifts left: rx_sh <= {rx_sh[DATA_WIDTH-2:0], MISO}.
- Undefined (default): LSB-first as above, required for the existing slave.
- All timing is identical in both modes.

Test Plan:
- Reset with CLK_DIV=3, then idle 10 cycles -> CS=1, SCLK=0, MOSI=0, busy=0, done=0, masterDataReceived=0.
- Loopback with the slave: send 8'b01010011 while the slave loads 8'b00001001 -> slave receives 8'b01010011; masterDataReceived=8'b00001001; exactly 8 SCLK rising edges while CS=0; done one cycle at latency 18*CLK_DIV+1.
- Back-to-back with start held high: 8'b00111100 then 8'b10011000, slave returns 8'b10011000 then 8'b00111100 -> both bytes correct; CS high at least CLK_DIV cycles between frames; two done pulses.
- Pulse start during XFER of 0xA5 with data 0xFF -> ignored; slave receives 0xA5; exactly one done.
- Assert reset after the 4th falling SCLK edge -> next edge: CS=1, SCLK=0, busy=0, masterDataReceived unchanged at 0. A following transfer of 0x3C completes correctly.
- With SPI_MASTER_MSB_FIRST_EN, send 0x80 against a bit-monitor -> first MOSI bit after CS falls is 1, remaining seven are 0.
